// File: rtl/bp_pkg.sv
// Shared types and constants for the branch-predictor update path.
package bp_pkg;

    localparam int ROB_WIDTH        = 4;
    localparam int LG_TABLE_DEFAULT = 5;

    // Pattern-history counter value written by the init sweep (weakly taken).
    localparam logic [1:0] PHT_INIT = 2'b10;

    typedef struct packed {
        logic [ROB_WIDTH-1:0] rob_id;
        logic [31:0]          pc;
        logic [31:0]          target;
        logic                 taken;
        logic                 mispredict;
    } bp_upd_t;

endpackage

// File: rtl/bp_upd_fifo.sv
// Synchronous update queue: up to two writes (wr_data0 first) and one read per cycle.
module bp_upd_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 wr_num,
    input  bp_upd_t                    wr_data0,
    input  bp_upd_t                    wr_data1,
    input  logic                       rd_en,
    output bp_upd_t                    rd_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    bp_upd_t      mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    // Pointers carry one extra wrap bit so full and empty differ.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr + (AW+1)'(wr_num);
            rd_ptr <= rd_ptr + (AW+1)'(rd_en);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_num != 2'd0)
            mem[wr_ptr[AW-1:0]] <= wr_data0;
        if (wr_num == 2'd2)
            mem[wr_ptr[AW-1:0] + AW'(1)] <= wr_data1;
    end

    assign rd_data = mem[rd_ptr[AW-1:0]];
    assign count   = wr_ptr - rd_ptr;

endmodule

// File: rtl/bp_update_scheduler.sv
// Single-port predictor update sequencer: post-reset table sweep, two-source arbitration, GHR recovery.
// Optional performance counters are enabled by defining BP_SCHED_PERF_EN.
module bp_update_scheduler
    import bp_pkg::*;
#(
    parameter int LG_TABLE   = LG_TABLE_DEFAULT,
    parameter int FIFO_DEPTH = 4,
    parameter int RW         = ROB_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  bp_upd_t [1:0]       req_pkt,
    input  logic [RW-1:0]       rob_head,
    output logic                upd_valid,
    output logic                upd_clear,
    output logic [LG_TABLE-1:0] upd_idx,
    output bp_upd_t             upd_pkt,
    output logic                recover_valid,
    output logic [RW-1:0]       recover_rob_id,
    output logic                recover_dir,
    output logic                bp_ready
`ifdef BP_SCHED_PERF_EN
    ,
    output logic [31:0]         perf_upd_cnt,
    output logic [31:0]         perf_mispred_cnt,
    output logic [31:0]         perf_stall_cnt
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                state_q, state_d;
    logic [LG_TABLE-1:0]   sweep_q, sweep_d;
    logic                  rr_q, rr_d;

    logic                  upd_valid_d, upd_clear_d, bp_ready_d;
    logic [LG_TABLE-1:0]   upd_idx_d;
    bp_upd_t               upd_pkt_d;
    logic                  rec_valid_d, rec_dir_d;
    logic [RW-1:0]         rec_id_d;

    logic                  run, pop, pick1;
    logic [CW-1:0]         fifo_cnt, occ;
    logic [1:0]            acc, mis, wr_num;
    bp_upd_t               fifo_head, first_pkt, wr_data0, wr_data1;

    // Distance from the ROB head; smaller means older.
    function automatic logic [RW-1:0] rob_age(input logic [RW-1:0] id, input logic [RW-1:0] head);
        return id - head;
    endfunction

    // Run phase begins once bp_ready is visible, so no request is taken while the last clear is on the port.
    assign run       = (state_q == ST_RUN) && bp_ready;
    assign pop       = run && (fifo_cnt != '0);
    assign occ       = fifo_cnt - CW'(pop);
    assign acc       = req_valid & req_ready;
    assign mis       = acc & {req_pkt[1].mispredict, req_pkt[0].mispredict};
    assign first_pkt = acc[0] ? req_pkt[0] : req_pkt[1];
    assign pick1     = mis[1] && (!mis[0] ||
                       (rob_age(RW'(req_pkt[1].rob_id), rob_head) < rob_age(RW'(req_pkt[0].rob_id), rob_head)));

    // Slot accounting includes this cycle's pop; one free slot goes to the round-robin winner.
    always_comb begin
        req_ready = 2'b00;
        rr_d      = rr_q;
        if (run) begin
            if (occ <= CW'(FIFO_DEPTH - 2)) begin
                req_ready = 2'b11;
            end else if (occ == CW'(FIFO_DEPTH - 1)) begin
                req_ready = rr_q ? 2'b10 : 2'b01;
                if (&req_valid)
                    rr_d = ~rr_q;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        sweep_d     = sweep_q;
        bp_ready_d  = (state_q == ST_RUN);
        upd_valid_d = 1'b0;
        upd_clear_d = 1'b0;
        upd_idx_d   = '0;
        upd_pkt_d   = upd_pkt;
        rec_valid_d = 1'b0;
        rec_id_d    = recover_rob_id;
        rec_dir_d   = recover_dir;
        wr_num      = 2'd0;
        wr_data0    = first_pkt;
        wr_data1    = req_pkt[1];
        unique case (state_q)
            ST_INIT: begin
                upd_valid_d = 1'b1;
                upd_clear_d = 1'b1;
                upd_idx_d   = sweep_q;
                sweep_d     = sweep_q + 1'b1;
                if (sweep_q == '1)
                    state_d = ST_RUN;
            end
            ST_RUN: begin
                // An empty queue lets the first accepted report bypass straight to the output register.
                if (pop) begin
                    upd_valid_d = 1'b1;
                    upd_pkt_d   = fifo_head;
                    wr_num      = {1'b0, acc[0]} + {1'b0, acc[1]};
                end else if (|acc) begin
                    upd_valid_d = 1'b1;
                    upd_pkt_d   = first_pkt;
                    wr_num      = {1'b0, &acc};
                    wr_data0    = req_pkt[1];
                end
                if (|mis) begin
                    rec_valid_d = 1'b1;
                    rec_id_d    = pick1 ? RW'(req_pkt[1].rob_id) : RW'(req_pkt[0].rob_id);
                    rec_dir_d   = pick1 ? req_pkt[1].taken : req_pkt[0].taken;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_INIT;
            sweep_q        <= '0;
            rr_q           <= 1'b0;
            upd_valid      <= 1'b0;
            upd_clear      <= 1'b0;
            upd_idx        <= '0;
            upd_pkt        <= '0;
            recover_valid  <= 1'b0;
            recover_rob_id <= '0;
            recover_dir    <= 1'b0;
            bp_ready       <= 1'b0;
        end else begin
            state_q        <= state_d;
            sweep_q        <= sweep_d;
            rr_q           <= rr_d;
            upd_valid      <= upd_valid_d;
            upd_clear      <= upd_clear_d;
            upd_idx        <= upd_idx_d;
            upd_pkt        <= upd_pkt_d;
            recover_valid  <= rec_valid_d;
            recover_rob_id <= rec_id_d;
            recover_dir    <= rec_dir_d;
            bp_ready       <= bp_ready_d;
        end
    end

    bp_upd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_num   (wr_num),
        .wr_data0 (wr_data0),
        .wr_data1 (wr_data1),
        .rd_en    (pop),
        .rd_data  (fifo_head),
        .count    (fifo_cnt)
    );

`ifdef BP_SCHED_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && (v != '1)) ? v + 32'd1 : v;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_upd_cnt     <= '0;
            perf_mispred_cnt <= '0;
            perf_stall_cnt   <= '0;
        end else begin
            perf_upd_cnt     <= sat_inc(perf_upd_cnt, upd_valid && !upd_clear);
            perf_mispred_cnt <= sat_inc(perf_mispred_cnt, recover_valid);
            perf_stall_cnt   <= sat_inc(perf_stall_cnt, |(req_valid & ~req_ready));
        end
    end
`endif

endmodule

// File: tb/tb_bp_update_scheduler.sv
// Bench for bp_update_scheduler: queue-level reference model plus directed vectors.
module tb_bp_update_scheduler;
    import bp_pkg::*;

    localparam int LGT   = 5;
    localparam int NIDX  = 32;
    localparam int DEPTH = 4;
    localparam int RWB   = 4;

    logic                clk;
    logic                rst;
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    bp_upd_t [1:0]       req_pkt;
    logic [RWB-1:0]      rob_head;
    logic                upd_valid;
    logic                upd_clear;
    logic [LGT-1:0]      upd_idx;
    bp_upd_t             upd_pkt;
    logic                recover_valid;
    logic [RWB-1:0]      recover_rob_id;
    logic                recover_dir;
    logic                bp_ready;

    bp_update_scheduler #(
        .LG_TABLE   (LGT),
        .FIFO_DEPTH (DEPTH),
        .RW         (RWB)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_pkt        (req_pkt),
        .rob_head       (rob_head),
        .upd_valid      (upd_valid),
        .upd_clear      (upd_clear),
        .upd_idx        (upd_idx),
        .upd_pkt        (upd_pkt),
        .recover_valid  (recover_valid),
        .recover_rob_id (recover_rob_id),
        .recover_dir    (recover_dir),
        .bp_ready       (bp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Reference model: pending updates as a plain queue, sweep as a position count.
    bit        m_sync = 1'b0;
    bit        m_init;
    int        m_pos;
    bit        m_run;
    bit        m_rr;
    bp_upd_t   mq[$];
    logic [1:0] m_rdy, m_acc;
    int        age0, age1;

    bit        e_upd_valid, e_upd_clear, e_rec_valid, e_rec_dir, e_bp_ready;
    int        e_idx;
    int        e_rec_id;
    bp_upd_t   e_pkt;

    function automatic logic [1:0] model_ready();
        int occ;
        int free;
        if (!m_run) return 2'b00;
        occ  = mq.size() - ((mq.size() > 0) ? 1 : 0);
        free = DEPTH - occ;
        if (free >= 2) return 2'b11;
        if (free == 1) return m_rr ? 2'b10 : 2'b01;
        return 2'b00;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_sync = 1'b1; m_init = 1'b1; m_pos = 0; m_run = 1'b0; m_rr = 1'b0;
            mq.delete();
            e_upd_valid = 0; e_upd_clear = 0; e_rec_valid = 0; e_rec_dir = 0;
            e_bp_ready = 0; e_idx = 0; e_rec_id = 0; e_pkt = '0;
        end else if (m_sync) begin
            m_rdy = model_ready();
            m_acc = req_valid & m_rdy;
            e_upd_valid = 0; e_upd_clear = 0; e_rec_valid = 0;
            if (m_init) begin
                e_upd_valid = 1; e_upd_clear = 1; e_idx = m_pos;
                m_pos++;
                if (m_pos == NIDX) m_init = 1'b0;
            end else begin
                if ((m_rdy == 2'b01 || m_rdy == 2'b10) && req_valid == 2'b11) m_rr = !m_rr;
                if (m_acc[0]) mq.push_back(req_pkt[0]);
                if (m_acc[1]) mq.push_back(req_pkt[1]);
                if (mq.size() > 0) begin
                    e_upd_valid = 1;
                    e_pkt = mq.pop_front();
                end
                age0 = (int'(req_pkt[0].rob_id) - int'(rob_head) + 16) % 16;
                age1 = (int'(req_pkt[1].rob_id) - int'(rob_head) + 16) % 16;
                if (m_acc[0] && req_pkt[0].mispredict &&
                    !(m_acc[1] && req_pkt[1].mispredict && age1 < age0)) begin
                    e_rec_valid = 1; e_rec_id = req_pkt[0].rob_id; e_rec_dir = req_pkt[0].taken;
                end else if (m_acc[1] && req_pkt[1].mispredict) begin
                    e_rec_valid = 1; e_rec_id = req_pkt[1].rob_id; e_rec_dir = req_pkt[1].taken;
                end
                e_bp_ready = 1;
                m_run = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_sync) begin
            chk("upd_valid", upd_valid, e_upd_valid);
            chk("upd_clear", upd_clear, e_upd_clear);
            chk("bp_ready", bp_ready, e_bp_ready);
            chk("recover_valid", recover_valid, e_rec_valid);
            chk("req_ready", req_ready, model_ready());
            if (e_upd_valid && e_upd_clear) chk("upd_idx", upd_idx, e_idx[LGT-1:0]);
            if (e_upd_valid && !e_upd_clear) chk("upd_pkt", upd_pkt, e_pkt);
            if (e_rec_valid) begin
                chk("recover_rob_id", recover_rob_id, e_rec_id[RWB-1:0]);
                chk("recover_dir", recover_dir, e_rec_dir);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic bp_upd_t mk(input int n, input int rid, input bit tk, input bit mp);
        bp_upd_t p;
        p.rob_id     = rid[RWB-1:0];
        p.pc         = 32'h1000 + 32'(n * 4);
        p.target     = 32'h8000 + 32'(n * 16);
        p.taken      = tk;
        p.mispredict = mp;
        return p;
    endfunction

    initial begin
        rst = 1'b1; req_valid = 2'b00; req_pkt = '0; rob_head = '0;
        repeat (3) tick();
        chk("rst_upd_valid", upd_valid, 1'b0);
        chk("rst_req_ready", req_ready, 2'b00);

        // Sweep interrupted at index 10, then a full sweep.
        rst = 1'b0;
        repeat (11) tick();
        chk("mid_init_idx", upd_idx, 5'd10);
        rst = 1'b1;
        tick();
        chk("mid_init_rst_valid", upd_valid, 1'b0);
        rst = 1'b0;
        tick();
        chk("restart_idx0", upd_idx, 5'd0);
        repeat (31) tick();
        chk("sweep_last_idx", upd_idx, 5'd31);
        chk("sweep_last_bp_ready", bp_ready, 1'b0);
        tick();
        chk("bp_ready_rise", bp_ready, 1'b1);
        chk("bp_ready_no_upd", upd_valid, 1'b0);

        // Single update from source 0.
        req_pkt[0] = '{rob_id: 4'd3, pc: 32'h100, target: 32'h180, taken: 1'b1, mispredict: 1'b0};
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        chk("single_valid", upd_valid, 1'b1);
        chk("single_clear", upd_clear, 1'b0);
        chk("single_pc", upd_pkt.pc, 32'h100);
        chk("single_target", upd_pkt.target, 32'h180);
        tick();

        // Both sources every cycle until the queue saturates and round-robin takes over.
        for (int i = 0; i < 8; i++) begin
            req_pkt[0] = mk(2 * i, i, 1'b0, 1'b0);
            req_pkt[1] = mk(2 * i + 1, i + 8, 1'b1, 1'b0);
            req_valid  = 2'b11;
            #1;
            if (i == 4) chk("rr_grant_src0", req_ready, 2'b01);
            if (i == 5) chk("rr_grant_src1", req_ready, 2'b10);
            tick();
            if (i == 0) chk("dual_first_pc", upd_pkt.pc, 32'h1000);
            if (i == 1) chk("dual_second_pc", upd_pkt.pc, 32'h1004);
        end
        // Full queue, only the non-winning source requests.
        req_valid = 2'b10;
        req_pkt[1] = mk(40, 1, 1'b0, 1'b0);
        tick();
        req_valid = 2'b00;
        repeat (5) tick();
        chk("drained", upd_valid, 1'b0);

        // Dual mispredict: head 14, ids 2 and 15; 15 is older.
        rob_head   = 4'd14;
        req_pkt[0] = mk(50, 2, 1'b0, 1'b1);
        req_pkt[1] = mk(51, 15, 1'b1, 1'b1);
        req_valid  = 2'b11;
        tick();
        req_valid = 2'b00;
        chk("dual_mp_valid", recover_valid, 1'b1);
        chk("dual_mp_rob_id", recover_rob_id, 4'd15);
        chk("dual_mp_dir", recover_dir, 1'b1);
        chk("dual_mp_train0", upd_pkt.rob_id, 4'd2);
        tick();
        chk("dual_mp_single_pulse", recover_valid, 1'b0);
        chk("dual_mp_train1", upd_pkt.rob_id, 4'd15);

        // Opposite age order, and a lone source-1 mispredict.
        rob_head   = 4'd1;
        req_pkt[0] = mk(60, 3, 1'b1, 1'b1);
        req_pkt[1] = mk(61, 0, 1'b0, 1'b1);
        req_valid  = 2'b11;
        tick();
        req_pkt[1] = mk(62, 7, 1'b0, 1'b1);
        req_valid  = 2'b10;
        tick();
        req_valid = 2'b00;
        repeat (3) tick();

        // Reset while entries are queued: queue flushed, sweep repeats.
        for (int i = 0; i < 4; i++) begin
            req_pkt[0] = mk(70 + i, i, 1'b0, 1'b0);
            req_pkt[1] = mk(80 + i, i, 1'b1, 1'b0);
            req_valid  = 2'b11;
            tick();
        end
        req_valid = 2'b00;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (NIDX + 1) tick();
        chk("flush_bp_ready", bp_ready, 1'b1);
        chk("flush_no_stale", upd_valid, 1'b0);
        req_pkt[1] = mk(90, 5, 1'b1, 1'b0);
        req_valid  = 2'b10;
        tick();
        req_valid = 2'b00;
        chk("post_flush_pc", upd_pkt.pc, 32'h1000 + 32'd360);
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
